// File: rtl/mem_handshake_ram_pkg.sv
// Shared definitions for the handshaked byte-addressed memory.
// Contents: access-size encodings, read/write strobe values, FSM state
// encoding and a helper that turns an access size into a byte-lane mask.
package mem_handshake_ram_pkg;

  localparam logic [1:0] SIZE_BYTE       = 2'b00;
  localparam logic [1:0] SIZE_HALF       = 2'b01;
  localparam logic [1:0] SIZE_WORD       = 2'b10;
  localparam logic [1:0] SIZE_WORD_ALIAS = 2'b11;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  // Lane 0 always holds the most significant byte of the access (big-endian),
  // so narrower accesses occupy the low-numbered lanes.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_handshake_ram_lane_steer.sv
// mem_lane_steer: combinational byte-lane steering for the handshaked memory.
// Ports:
//   addr       in   request byte address (unaligned)
//   size       in   access size (byte / halfword / word)
//   wdata      in   right-justified write data
//   rd_bytes   in   memory bytes currently addressed by each lane
//   lane_addr  out  byte address of each lane (aligned base + lane, wrapping)
//   lane_we    out  per-lane write enable
//   lane_wdata out  per-lane write byte
//   rdata      out  assembled, zero-extended, right-justified read word
module mem_lane_steer
  import mem_handshake_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [1:0]                  size,
  input  logic [31:0]                 wdata,
  input  logic [3:0][7:0]             rd_bytes,
  output logic [3:0][ADDR_WIDTH-1:0]  lane_addr,
  output logic [3:0]                  lane_we,
  output logic [3:0][7:0]             lane_wdata,
  output logic [31:0]                 rdata
);

  logic [ADDR_WIDTH-1:0] base_s;

  // Align the address, fan out lane addresses, steer write bytes and assemble read data.
  always_comb begin
    base_s = addr;
    case (size)
      SIZE_BYTE: base_s = addr;
      SIZE_HALF: base_s[0] = 1'b0;
      default:   base_s[1:0] = 2'b00;
    endcase

    // Truncation to ADDR_WIDTH gives the modulo-DEPTH wrap.
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = base_s + ADDR_WIDTH'(k);
    end

    lane_we = lane_mask(size);

    lane_wdata = '0;
    case (size)
      SIZE_BYTE: begin
        lane_wdata[0] = wdata[7:0];
      end
      SIZE_HALF: begin
        lane_wdata[0] = wdata[15:8];
        lane_wdata[1] = wdata[7:0];
      end
      default: begin
        lane_wdata[0] = wdata[31:24];
        lane_wdata[1] = wdata[23:16];
        lane_wdata[2] = wdata[15:8];
        lane_wdata[3] = wdata[7:0];
      end
    endcase

    case (size)
      SIZE_BYTE: rdata = {24'h000000, rd_bytes[0]};
      SIZE_HALF: rdata = {16'h0000, rd_bytes[0], rd_bytes[1]};
      default:   rdata = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
    endcase
  end

endmodule

// File: rtl/mem_handshake_ram.sv
// mem_handshake_ram: big-endian byte-addressed memory with a MOV/MOC
// handshake and WAIT_STATES wait cycles between acceptance and completion.
// Ports:
//   CLK        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   MOV        in   memory operation valid, held until MOC
//   ReadWrite  in   1 = read, 0 = write
//   Address    in   byte address
//   Size       in   00 byte, 01 halfword, 1x word
//   DataIn     in   right-justified write data
//   DataOut    out  registered read data, zero-extended
//   MOC        out  registered operation-complete flag
module mem_handshake_ram
  import mem_handshake_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [1:0]            Size,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MOC
);

  localparam bit         NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  // Not cleared by reset; preloaded by the environment.
  logic [7:0] Memory [0:DEPTH-1];

  state_t                    state_r, state_nxt_s;
  logic [3:0]                cnt_r, cnt_nxt_s;
  logic [ADDR_WIDTH-1:0]     lat_addr_r;
  logic [1:0]                lat_size_r;
  logic                      lat_rw_r;
  logic [31:0]               lat_data_r;
  logic [31:0]               data_out_r;
  logic                      moc_r;
  logic                      accept_s, commit_s;

  logic [ADDR_WIDTH-1:0]     req_addr_s;
  logic [1:0]                req_size_s;
  logic                      req_rw_s;
  logic [31:0]               req_data_s;

  logic [3:0][ADDR_WIDTH-1:0] lane_addr_s;
  logic [3:0]                 lane_we_s;
  logic [3:0][7:0]            lane_wdata_s;
  logic [3:0][7:0]            rd_bytes_s;
  logic [31:0]                rdata_s;

  // With no wait states a request completes on its acceptance edge, so the
  // live inputs must feed the lane steering while idle.
  always_comb begin
    if (state_r == IDLE) begin
      req_addr_s = Address;
      req_size_s = Size;
      req_rw_s   = ReadWrite;
      req_data_s = DataIn;
    end else begin
      req_addr_s = lat_addr_r;
      req_size_s = lat_size_r;
      req_rw_s   = lat_rw_r;
      req_data_s = lat_data_r;
    end
  end

  mem_lane_steer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_steer (
    .addr       (req_addr_s),
    .size       (req_size_s),
    .wdata      (req_data_s),
    .rd_bytes   (rd_bytes_s),
    .lane_addr  (lane_addr_s),
    .lane_we    (lane_we_s),
    .lane_wdata (lane_wdata_s),
    .rdata      (rdata_s)
  );

  // Fetch the byte under each lane address.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_bytes_s[k] = Memory[lane_addr_s[k]];
    end
  end

  // Next-state, wait counter and accept/commit decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (MOV) begin
          accept_s = 1'b1;
          if (NO_WAIT) begin
            state_nxt_s = DONE;
            commit_s    = 1'b1;
          end else begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = WS_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!MOV) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = DONE;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        if (!MOV) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, request latch, read data and completion flag registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      lat_addr_r <= '0;
      lat_size_r <= 2'b00;
      lat_rw_r   <= 1'b0;
      lat_data_r <= 32'h0000_0000;
      data_out_r <= 32'h0000_0000;
      moc_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        lat_addr_r <= Address;
        lat_size_r <= Size;
        lat_rw_r   <= ReadWrite;
        lat_data_r <= DataIn;
      end
      if (commit_s && (req_rw_s == READ)) begin
        data_out_r <= rdata_s;
      end
      moc_r <= (state_nxt_s == DONE);
    end
  end

  // Commit write bytes; gated by reset so nothing lands while reset is held.
  always_ff @(posedge CLK) begin
    if (reset && commit_s && (req_rw_s == WRITE)) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we_s[k]) begin
          Memory[lane_addr_s[k]] <= lane_wdata_s[k];
        end
      end
    end
  end

  assign DataOut = data_out_r;
  assign MOC     = moc_r;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Self-checking bench for mem_handshake_ram: two instances (2 and 0 wait
// states) share one stimulus stream; a transaction-level model per instance
// predicts MOC/DataOut every cycle, and directed literal checks pin the model.
module tb_mem_handshake_ram;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        MOV;
  logic        ReadWrite;
  logic [7:0]  Address;
  logic [1:0]  Size;
  logic [31:0] DataIn;
  logic [31:0] do2, do0;
  logic        moc2, moc0;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 CLK = ~CLK;

  mem_handshake_ram #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .CLK(CLK), .reset(rst_n), .MOV(MOV), .ReadWrite(ReadWrite), .Address(Address),
    .Size(Size), .DataIn(DataIn), .DataOut(do2), .MOC(moc2));

  mem_handshake_ram #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .reset(rst_n), .MOV(MOV), .ReadWrite(ReadWrite), .Address(Address),
    .Size(Size), .DataIn(DataIn), .DataOut(do0), .MOC(moc0));

  // Model state: index 0 models u_ws2, index 1 models u_ws0.
  int          ws [2] = '{2, 0};
  logic [7:0]  mm [2][256];
  bit          m_busy [2];
  bit          m_done [2];
  int          m_edges [2];
  logic        r_rw [2];
  logic [7:0]  r_a [2];
  logic [1:0]  r_sz [2];
  logic [31:0] r_d [2];
  logic        exp_moc [2];
  logic [31:0] exp_do [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] align(input logic [7:0] a, input logic [1:0] s);
    if (s == 2'b00) return a;
    else if (s == 2'b01) return a & 8'hFE;
    else return a & 8'hFC;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    else if (s == 2'b01) return 2;
    else return 4;
  endfunction

  // Perform the completed access against the model memory (big-endian).
  task automatic finish_req(input int u);
    logic [7:0]  b;
    logic [31:0] v;
    int          n;
    b = align(r_a[u], r_sz[u]);
    n = nbytes(r_sz[u]);
    if (r_rw[u]) begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, mm[u][8'(b + k)]};
      exp_do[u] = v;
    end else begin
      for (int k = 0; k < n; k++) mm[u][8'(b + k)] = r_d[u][8*(n-1-k) +: 8];
    end
    m_busy[u]  = 1'b0;
    m_done[u]  = 1'b1;
    exp_moc[u] = 1'b1;
  endtask

  task automatic mstep(input int u);
    if (m_done[u]) begin
      if (!MOV) begin
        m_done[u]  = 1'b0;
        exp_moc[u] = 1'b0;
      end
    end else if (m_busy[u]) begin
      if (!MOV) m_busy[u] = 1'b0;
      else begin
        m_edges[u]++;
        if (m_edges[u] >= ws[u]) finish_req(u);
      end
    end else if (MOV) begin
      r_rw[u] = ReadWrite; r_a[u] = Address; r_sz[u] = Size; r_d[u] = DataIn;
      m_edges[u] = 0;
      m_busy[u]  = 1'b1;
      if (ws[u] == 0) finish_req(u);
    end
  endtask

  always @(posedge CLK or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_busy[u] = 1'b0; m_done[u] = 1'b0; m_edges[u] = 0;
        exp_moc[u] = 1'b0; exp_do[u] = 32'h0;
      end else begin
        mstep(u);
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("moc_ws2", {31'h0, moc2}, {31'h0, exp_moc[0]});
      chk("dataout_ws2", do2, exp_do[0]);
      chk("moc_ws0", {31'h0, moc0}, {31'h0, exp_moc[1]});
      chk("dataout_ws0", do0, exp_do[1]);
    end
  end

  task automatic pre(input logic [7:0] a, input logic [7:0] v);
    u_ws2.Memory[a] = v; u_ws0.Memory[a] = v;
    mm[0][a] = v; mm[1][a] = v;
  endtask

  // One request: MOV held for 'hold' edges, inputs scrambled after acceptance,
  // then MOV low for one idle edge. Reports first edge (1-based) with MOC high.
  task automatic op(input logic rw, input logic [7:0] a, input logic [1:0] sz,
                    input logic [31:0] d, input int hold,
                    output int lat2, output int lat0, output int c2, output int c0);
    lat2 = -1; lat0 = -1; c2 = 0; c0 = 0;
    MOV = 1'b1; ReadWrite = rw; Address = a; Size = sz; DataIn = d;
    for (int e = 1; e <= hold; e++) begin
      @(posedge CLK); #1;
      if (moc2) begin c2++; if (lat2 < 0) lat2 = e; end
      if (moc0) begin c0++; if (lat0 < 0) lat0 = e; end
      if (e == 1) begin
        ReadWrite = ~rw; Address = ~a; Size = ~sz; DataIn = ~d;
      end
    end
    MOV = 1'b0;
    @(posedge CLK); #1;
  endtask

  int l2, l0, c2, c0;
  int bad;

  initial begin
    rst_n = 1'b0; MOV = 1'b0; ReadWrite = 1'b1; Address = 8'h00; Size = 2'b00;
    DataIn = 32'h0;
    for (int i = 0; i < 256; i++) pre(8'(i), 8'(i * 7 + 3));
    pre(8'h04, 8'h11); pre(8'h05, 8'h22); pre(8'h06, 8'h33); pre(8'h07, 8'h44);
    pre(8'hFC, 8'h01); pre(8'hFD, 8'h02); pre(8'h00, 8'h77);
    pre(8'd20, 8'h99); pre(8'h30, 8'hE1);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_moc", {31'h0, moc2}, 32'h0);
    chk("reset_dataout", do2, 32'h0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge CLK); #1;

    // 1: word write then read at 8
    op(1'b0, 8'd8, 2'b10, 32'hDEADBEEF, 5, l2, l0, c2, c0);
    chk("wr_latency_ws2", 32'(l2), 32'd3);
    chk("wr_latency_ws0", 32'(l0), 32'd1);
    chk("mem8", {24'h0, u_ws2.Memory[8]}, 32'hDE);
    chk("mem9", {24'h0, u_ws2.Memory[9]}, 32'hAD);
    chk("mem10", {24'h0, u_ws2.Memory[10]}, 32'hBE);
    chk("mem11", {24'h0, u_ws2.Memory[11]}, 32'hEF);
    op(1'b1, 8'd8, 2'b10, 32'h0, 5, l2, l0, c2, c0);
    chk("rd_latency_ws2", 32'(l2), 32'd3);
    chk("rd_word8", do2, 32'hDEADBEEF);

    // 2: byte and halfword reads
    op(1'b1, 8'd6, 2'b00, 32'h0, 5, l2, l0, c2, c0);
    chk("rd_byte6", do2, 32'h00000033);
    op(1'b1, 8'd5, 2'b01, 32'h0, 5, l2, l0, c2, c0);
    chk("rd_half5", do2, 32'h00001122);

    // 3: top-of-memory halfword write and word reads
    op(1'b0, 8'hFF, 2'b01, 32'h0000ABCD, 5, l2, l0, c2, c0);
    chk("memFE", {24'h0, u_ws2.Memory[8'hFE]}, 32'hAB);
    chk("memFF", {24'h0, u_ws2.Memory[8'hFF]}, 32'hCD);
    chk("mem00_untouched", {24'h0, u_ws2.Memory[8'h00]}, 32'h77);
    op(1'b1, 8'hFE, 2'b10, 32'h0, 5, l2, l0, c2, c0);
    chk("rd_wordFE", do2, 32'h0102ABCD);
    op(1'b1, 8'hFF, 2'b11, 32'h0, 5, l2, l0, c2, c0);
    chk("rd_wordFF_alias", do0, 32'h0102ABCD);

    // 4: aborted byte write
    op(1'b0, 8'd20, 2'b00, 32'h0000005A, 1, l2, l0, c2, c0);
    chk("abort_no_moc", 32'(l2), 32'hFFFFFFFF);
    chk("abort_mem20", {24'h0, u_ws2.Memory[20]}, 32'h99);
    chk("ws0_mem20", {24'h0, u_ws0.Memory[20]}, 32'h5A);
    chk("abort_dataout_held", do2, 32'h0102ABCD);

    // 5: reset during WAIT of a write
    MOV = 1'b1; ReadWrite = 1'b0; Address = 8'h30; Size = 2'b00; DataIn = 32'h000000C3;
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b0; MOV = 1'b0;
    #1;
    chk("rst_mid_moc", {31'h0, moc2}, 32'h0);
    chk("rst_mid_dataout", do2, 32'h0);
    chk("rst_mid_dataout_ws0", do0, 32'h0);
    @(posedge CLK); #1;
    rst_n = 1'b1;
    chk("rst_mem30", {24'h0, u_ws2.Memory[8'h30]}, 32'hE1);
    chk("rst_mem4_intact", {24'h0, u_ws2.Memory[8'h04]}, 32'h11);
    @(posedge CLK); #1;

    // 6: zero-wait instance with MOV held through DONE
    op(1'b1, 8'd4, 2'b10, 32'h0, 4, l2, l0, c2, c0);
    chk("ws0_latency", 32'(l0), 32'd1);
    chk("ws0_moc_held", 32'(c0), 32'd4);
    chk("ws2_moc_held", 32'(c2), 32'd2);
    chk("ws0_word4", do0, 32'h11223344);
    chk("ws0_moc_dropped", {31'h0, moc0}, 32'h0);
    op(1'b1, 8'd8, 2'b01, 32'h0, 3, l2, l0, c2, c0);
    chk("ws0_next_latency", 32'(l0), 32'd1);
    chk("ws0_half8", do0, 32'h0000DEAD);

    // Full memory image against the model
    bad = 0;
    for (int i = 0; i < 256; i++) if (u_ws2.Memory[i] !== mm[0][i]) bad++;
    chk("image_ws2_bad_bytes", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (u_ws0.Memory[i] !== mm[1][i]) bad++;
    chk("image_ws0_bad_bytes", 32'(bad), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
